// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped timer: bus widths, register offsets
// and CTRL bit positions.
package mmio_timer_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned REG_IDX_W = 2;

   localparam logic [REG_IDX_W-1:0] TMR_CTRL     = 2'd0;
   localparam logic [REG_IDX_W-1:0] TMR_PRESCALE = 2'd1;
   localparam logic [REG_IDX_W-1:0] TMR_COMPARE  = 2'd2;
   localparam logic [REG_IDX_W-1:0] TMR_COUNT    = 2'd3;

   localparam int unsigned CTRL_EN          = 0;
   localparam int unsigned CTRL_AUTO_RELOAD = 1;
   localparam int unsigned CTRL_CLR         = 2;
   localparam int unsigned CTRL_IE          = 3;
   localparam int unsigned CTRL_MATCH       = 6;

endpackage

// File: rtl/addr_detect.sv
// Masked address compare producing a chip select for a peripheral window.
module addr_detect
   import mmio_timer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] base_addr = 8'h80,
   parameter logic [ADDR_W-1:0] addr_mask = 8'hFC
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_cs_c
);

   assign o_cs_c = ((i_addr ^ base_addr) & addr_mask) == '0;

endmodule

// File: rtl/mmio_timer.sv
// 8-bit memory-mapped timer/counter with prescaler, compare match and irq.
// Optional toggle output on match events enabled by `define TIMER_TOGGLE_OUT_EN.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'h80,
   parameter logic [ADDR_W-1:0] ADDR_MASK      = 8'hFC,
   parameter int unsigned       PRESCALE_WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   inout  wire  [DATA_W-1:0] data,
   input  logic              mw,
   input  logic              mr,
   output logic              irq,
   output logic              tout
);

   logic                      w_cs;
   logic                      w_wr;
   logic                      w_rd;
   logic [REG_IDX_W-1:0]      w_idx;
   logic                      w_wr_ctrl;
   logic                      w_wr_pre;
   logic                      w_wr_cmp;
   logic                      w_wr_cnt;
   logic                      w_clr;
   logic                      w_tick;
   logic                      w_hit;
   logic                      w_match_set;
   logic [DATA_W-1:0]         w_rdata;

   logic                      r_en;
   logic                      r_auto;
   logic                      r_ie;
   logic                      r_match;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [PRESCALE_WIDTH-1:0] r_pcnt;
   logic [DATA_W-1:0]         r_compare;
   logic [DATA_W-1:0]         r_count;

   addr_detect #(
      .base_addr (BASE_ADDR),
      .addr_mask (ADDR_MASK)
   ) u_addr_detect (
      .i_addr (addr),
      .o_cs_c (w_cs)
   );

   // A simultaneous read and write strobe is treated as neither.
   assign w_idx     = addr[REG_IDX_W-1:0];
   assign w_wr      = w_cs & mw & ~mr;
   assign w_rd      = w_cs & mr & ~mw;
   assign w_wr_ctrl = w_wr & (w_idx == TMR_CTRL);
   assign w_wr_pre  = w_wr & (w_idx == TMR_PRESCALE);
   assign w_wr_cmp  = w_wr & (w_idx == TMR_COMPARE);
   assign w_wr_cnt  = w_wr & (w_idx == TMR_COUNT);
   assign w_clr     = w_wr_ctrl & data[CTRL_CLR];

   assign w_tick      = r_en & (r_pcnt == r_prescale);
   assign w_hit       = r_count == r_compare;
   // CLR and a COUNT write both pre-empt the tick, so no match is evaluated.
   assign w_match_set = w_tick & w_hit & ~w_clr & ~w_wr_cnt;

   // Prescaler: free-runs 0..PRESCALE while enabled, parked at 0 otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pcnt <= '0;
      end else if (w_wr_pre || w_clr || !r_en || w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_clr) begin
         r_count <= '0;
      end else if (w_wr_cnt) begin
         r_count <= data;
      end else if (w_tick) begin
         if (!w_hit) begin
            r_count <= r_count + DATA_W'(1);
         end else if (r_auto) begin
            r_count <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prescale <= '0;
         r_compare  <= 8'hFF;
      end else begin
         if (w_wr_pre) begin
            r_prescale <= PRESCALE_WIDTH'(data);
         end
         if (w_wr_cmp) begin
            r_compare <= data;
         end
      end
   end

   // Control bits; a bus write of CTRL overrides the one-shot self-disable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_en   <= 1'b0;
         r_auto <= 1'b0;
         r_ie   <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en   <= data[CTRL_EN];
         r_auto <= data[CTRL_AUTO_RELOAD];
         r_ie   <= data[CTRL_IE];
      end else if (w_match_set && !r_auto) begin
         r_en   <= 1'b0;
      end
   end

   // MATCH: a new set event beats a write-1-to-clear in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_match <= 1'b0;
      end else if (w_match_set) begin
         r_match <= 1'b1;
      end else if (w_wr_ctrl && data[CTRL_MATCH]) begin
         r_match <= 1'b0;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         TMR_CTRL: begin
            w_rdata[CTRL_EN]          = r_en;
            w_rdata[CTRL_AUTO_RELOAD] = r_auto;
            w_rdata[CTRL_IE]          = r_ie;
            w_rdata[CTRL_MATCH]       = r_match;
         end
         TMR_PRESCALE: w_rdata = DATA_W'(r_prescale);
         TMR_COMPARE:  w_rdata = r_compare;
         TMR_COUNT:    w_rdata = r_count;
         default:      w_rdata = '0;
      endcase
   end

   assign data = w_rd ? w_rdata : {DATA_W{1'bz}};
   assign irq  = r_match & r_ie;

`ifdef TIMER_TOGGLE_OUT_EN
   logic r_tout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tout <= 1'b0;
      end else if (w_match_set) begin
         r_tout <= ~r_tout;
      end
   end

   assign tout = r_tout;
`else
   assign tout = 1'b0;
`endif

endmodule
